bus_tx_scheduler: RTL
=====================

BUS_TX_SCHEDULER -- requirements
Module: bus_tx_scheduler

Interface
REQ-001 Parameter BASE_ADDR, default 0, base address of the target bus slave (STATUS = BASE_ADDR+0, DATA_TX = BASE_ADDR+1).
REQ-002 Parameter FIFO_DEPTH, default 4, power of two ≥2, number of queued transmit words.
REQ-003 Parameter SETTLE_CYCLES, default 3, range 1..15, wait cycles after a DATA_TX write before re-polling STATUS.
REQ-004 HCLK_i  input  1  sole clock, all state updates on rising edge.
REQ-005 HRESET_i  input  1  reset, asynchronous, active-high.
REQ-006 enable_i  input  1  1 = scheduling permitted; 0 = finish current transaction, then hold in IDLE.
REQ-007 req_data_bi  input  32  transmit word from requester.
REQ-008 req_wr_i  input  1  push strobe, one word per cycle with req_wr_i=1.
REQ-009 full_o  output  1  FIFO full; a push while full is dropped.
REQ-010 empty_o  output  1  FIFO empty.
REQ-011 HADDR_bo  output  32  bus address to slave, registered.
REQ-012 HWDATA_bo  output  32  bus write data, registered.
REQ-013 HWRITE_o  output  1  bus write strobe, registered, single-cycle per write.
REQ-014 HRDATA_bi  input  32  slave read data, valid two cycles after the address is driven.
REQ-015 sent_cnt_bo  output  16  count of words written to DATA_TX, wraps 0xFFFF->0.
REQ-016 drop_o  output  1  one-cycle pulse when a push is dropped (full).

Function
REQ-017 FSM states SHALL be IDLE, POLL, WAIT, CHECK, WRITE, SETTLE.
REQ-018 IDLE: HADDR_bo=BASE_ADDR+0, HWRITE_o=0; go to POLL when enable_i=1 and FIFO not empty.
REQ-019 POLL: HADDR_bo=BASE_ADDR+0, HWRITE_o=0 for exactly one cycle; next state WAIT.
REQ-020 WAIT: one cycle, bus outputs unchanged; next state CHECK.
REQ-021 CHECK: sample HRDATA_bi[0]; 1 (busy) -> POLL; 0 -> WRITE.
REQ-022 WRITE: exactly one cycle with HADDR_bo=BASE_ADDR+1, HWDATA_bo=FIFO head, HWRITE_o=1; FIFO popped and sent_cnt_bo incremented on this cycle; next state SETTLE.
REQ-023 SETTLE: HWRITE_o=0, HADDR_bo=BASE_ADDR+0, counter runs SETTLE_CYCLES cycles, then IDLE.
REQ-024 HWDATA_bo SHALL hold its last written value outside WRITE.
REQ-025 enable_i deassert in POLL/WAIT/CHECK SHALL abort to IDLE without writing; deassert in WRITE/SETTLE SHALL complete the sequence first.
REQ-026 Minimum word-to-word spacing with slave idle SHALL be 4+SETTLE_CYCLES+1 cycles (IDLE included).
REQ-027 Simultaneous push and pop SHALL succeed when FIFO full (occupancy unchanged, no drop).
REQ-028 Push when full without pop SHALL be ignored and pulse drop_o for one cycle.
REQ-029 FIFO SHALL preserve order; pointers wrap modulo FIFO_DEPTH; occupancy width clog2(FIFO_DEPTH)+1.
REQ-030 HRDATA_bi bits [31:1] SHALL be ignored.

Reset
REQ-031 On HRESET_i=1, asynchronously: state=IDLE, HADDR_bo=BASE_ADDR, HWDATA_bo=0, HWRITE_o=0, sent_cnt_bo=0, drop_o=0, FIFO emptied (empty_o=1, full_o=0), settle counter=0.
REQ-032 Reset asserted mid-WRITE SHALL discard the word without incrementing sent_cnt_bo.
REQ-033 Normal operation resumes on the first rising edge after HRESET_i falls.

Structure
REQ-034 FSM state encoding and register offsets (STATUS=0, DATA_TX=1, DATA_RX=2) SHALL live in a shared package bus_pkg.
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, same clock/reset).

Verification
REQ-036 Push 0xA5A5_0001 with slave busy=0, enable_i=1 -> single HWRITE_o pulse, HADDR_bo=BASE_ADDR+1, HWDATA_bo=0xA5A5_0001, 4 cycles after push; sent_cnt_bo=1.
REQ-037 Slave busy=1 for 20 cycles, one word queued -> repeated POLL/WAIT/CHECK, no HWRITE_o until busy clears, then exactly one write.
REQ-038 Push 5 words (depth 4) back-to-back while enable_i=0 -> full_o=1 after 4th, drop_o pulse on 5th, later 4 writes in order only.
REQ-039 Push and pop in same cycle while full -> full_o stays 1, no drop_o.
REQ-040 Assert HRESET_i during WRITE with 2 words queued -> all outputs at reset values immediately, sent_cnt_bo=0, empty_o=1.
REQ-041 Write 0x10000 words with busy=0 -> sent_cnt_bo wraps to 0, data order intact.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the transmit scheduler: FSM encoding, slave register
// offsets and the registered bus request payload.
package bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SET_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POLL   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WRITE  = 3'd4,
    ST_SETTLE = 3'd5
  } sched_state_t;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_DATA_TX = 2'd1,
    REG_DATA_RX = 2'd2
  } reg_off_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } bus_req_t;

  // Absolute slave register address from the slave base and a register offset.
  function automatic logic [DATA_W-1:0] reg_addr(input logic [DATA_W-1:0] base,
                                                 input reg_off_t          off);
    return base + DATA_W'(off);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted only when a pop happens on
// the same edge, otherwise it is dropped and reported with a one-cycle pulse.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      drop  <= push & full & ~do_pop;
    end
  end

  // Storage carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_tx_scheduler.sv
// Drains queued transmit words into a bus slave: poll STATUS until not busy,
// write one word to DATA_TX, settle, repeat.
module bus_tx_scheduler
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic        HCLK_i,
  input  logic        HRESET_i,
  input  logic        enable_i,
  input  logic [31:0] req_data_bi,
  input  logic        req_wr_i,
  output logic        full_o,
  output logic        empty_o,
  output logic [31:0] HADDR_bo,
  output logic [31:0] HWDATA_bo,
  output logic        HWRITE_o,
  input  logic [31:0] HRDATA_bi,
  output logic [15:0] sent_cnt_bo,
  output logic        drop_o
);

  sched_state_t      state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  bus_req_t          bus_q, bus_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              pop_c;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              unused_hrdata_c;

  // Only the busy flag of STATUS matters.
  assign unused_hrdata_c = ^HRDATA_bi[31:1];

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK_i),
    .rst   (HRESET_i),
    .push  (req_wr_i),
    .din   (req_data_bi),
    .pop   (pop_c),
    .dout  (fifo_head),
    .full  (full_o),
    .empty (fifo_empty),
    .drop  (drop_o)
  );

  assign empty_o = fifo_empty;

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      bus_q    <= '{addr: BASE_ADDR, wdata: '0, write: 1'b0};
      sent_q   <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      bus_q    <= bus_d;
      sent_q   <= sent_d;
    end
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pop_c    = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (enable_i && !fifo_empty) state_d = ST_POLL;
      ST_POLL:   state_d = enable_i ? ST_WAIT : ST_IDLE;
      ST_WAIT:   state_d = enable_i ? ST_CHECK : ST_IDLE;
      ST_CHECK: begin
        if (!enable_i)        state_d = ST_IDLE;
        else if (HRDATA_bi[0]) state_d = ST_POLL;
        else begin
          state_d = ST_WRITE;
          pop_c   = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default:   state_d = ST_IDLE;
    endcase

    bus_d.write = (state_d == ST_WRITE);
    bus_d.addr  = reg_addr(BASE_ADDR, bus_d.write ? REG_DATA_TX : REG_STATUS);
    bus_d.wdata = bus_d.write ? fifo_head : bus_q.wdata;
    sent_d      = bus_d.write ? sent_q + CNT_W'(1) : sent_q;
  end

  assign HADDR_bo    = bus_q.addr;
  assign HWDATA_bo   = bus_q.wdata;
  assign HWRITE_o    = bus_q.write;
  assign sent_cnt_bo = sent_q;

endmodule
